// File: rtl/paced_fifo_pkg.sv
// Shared constants and helpers for the paced FIFO and its pace divider.
package paced_fifo_pkg;

    // Values for the OVERWRITE parameter: what happens to a write into a full buffer.
    localparam int FULL_DROP_NEW      = 0;
    localparam int FULL_OVERWRITE_OLD = 1;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // The occupancy count needs one extra bit so that DEPTH itself is representable.
    function automatic int level_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pace_divider.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module pace_divider
    import paced_fifo_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign tick   = w_wrap;

    // Count 0..DIV-1 and wrap; runs regardless of buffer state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/paced_fifo.sv
// Single-clock FIFO drained at a fixed pace, with drop-new or overwrite-old full policy.
module paced_fifo
    import paced_fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int DIV       = 4,
    parameter int AF_THRESH = 6,
    parameter int OVERWRITE = FULL_DROP_NEW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        data_in_en,
    input  logic [WIDTH-1:0]            data_in,
    input  logic                        clear_overflow,
    output logic                        data_out_valid,
    output logic [WIDTH-1:0]            data_out,
    output logic                        buffer_empty,
    output logic                        buffer_full,
    output logic                        almost_full,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        overflow
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [LW-1:0]    r_level;
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf;

    logic             w_tick;
    logic             w_full;
    logic             w_pop;
    logic             w_ovw;
    logic             w_drop;
    logic             w_wr_en;
    logic             w_rd_adv;
    logic [AW:0]      w_wr_nxt;
    logic [AW:0]      w_rd_nxt;

    pace_divider #(.DIV(DIV)) u_pace (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // A tick on an empty buffer is simply lost; a same-edge write cannot be popped yet.
    assign w_full   = (r_level == LW'(DEPTH));
    assign w_pop    = w_tick && (r_level != '0);
    assign w_ovw    = data_in_en && w_full && !w_pop && (OVERWRITE == FULL_OVERWRITE_OLD);
    assign w_drop   = data_in_en && w_full && !w_pop && (OVERWRITE == FULL_DROP_NEW);
    assign w_wr_en  = data_in_en && !w_drop;
    assign w_rd_adv = w_pop || w_ovw;
    assign w_wr_nxt = r_wr + {{AW{1'b0}}, w_wr_en};
    assign w_rd_nxt = r_rd + {{AW{1'b0}}, w_rd_adv};

    // Storage is never cleared; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            r_mem[r_wr[AW-1:0]] <= data_in;
        end
    end

    // Pointers and level; an overwrite advances both pointers so the level is unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_level <= w_wr_nxt - w_rd_nxt;
        end
    end

    // Output word register with a one-cycle valid pulse per pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_dout <= r_mem[r_rd[AW-1:0]];
            end
        end
    end

    // Sticky overflow; a new loss on the clearing edge keeps it set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop || w_ovw) begin
            r_ovf <= 1'b1;
        end else if (clear_overflow) begin
            r_ovf <= 1'b0;
        end
    end

    assign data_out_valid = r_valid;
    assign data_out       = r_dout;
    assign level          = r_level;
    assign buffer_empty   = (r_level == '0);
    assign buffer_full    = w_full;
    assign almost_full    = (r_level >= LW'(AF_THRESH));
    assign overflow       = r_ovf;

endmodule
